hls_run_sequencer: RTL and testbench

- Synthesizable front-end for an HLS-generated top module (e.g. main); owns one execution run end-to-end.
- Accepts a configuration word and a byte stream of initial memory contents.
- Preloads the DUT's slave RAM port byte by byte, pulses start_port, counts cycles until done_port, enforces a watchdog, and reports cycle count and timeout status.
- Sits directly upstream of the DUT, replacing file-driven stimulus in hardware-in-the-loop runs.

---
 rtl/hls_seq_pkg.sv | 22 ++
 rtl/hls_cycle_watchdog.sv | 41 ++++
 rtl/hls_run_sequencer.sv | 159 +++++++++++++++
 tb/tb_hls_run_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hls_seq_pkg.sv
// rtl/hls_seq_pkg.sv - shared state type, size constant and default widths for the run sequencer
package hls_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_START,
    ST_RUN,
    ST_REPORT
  } seq_state_t;

  localparam int SIZE_BYTE = 8;

  localparam int          DEF_ADDR_W     = 9;
  localparam int          DEF_DATA_W     = 64;
  localparam int          DEF_SIZE_W     = 7;
  localparam int          DEF_NCH        = 2;
  localparam int          DEF_CNT_W      = 32;
  localparam int unsigned DEF_MAX_CYCLES = 200000000;

endpackage

// File: rtl/hls_cycle_watchdog.sv
// rtl/hls_cycle_watchdog.sv - run cycle counter with done/limit compare and saturating result
module hls_cycle_watchdog
  import hls_seq_pkg::*;
#(
  parameter int          CNT_W      = DEF_CNT_W,
  parameter int unsigned MAX_CYCLES = DEF_MAX_CYCLES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic             done,
  output logic             finish,
  output logic [CNT_W-1:0] result_cycles,
  output logic             result_timeout
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;

  assign count_inc = count + ONE;

  // Completion beats the limit when both land in the same cycle.
  assign finish         = enable && (done || (count_inc == LIMIT));
  assign result_cycles  = done ? count_inc : LIMIT;
  assign result_timeout = !done;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count_inc;
    end
  end

endmodule

// File: rtl/hls_run_sequencer.sv
// rtl/hls_run_sequencer.sv - preloads slave RAM channel 0, starts the HLS top and times one run
module hls_run_sequencer
  import hls_seq_pkg::*;
#(
  parameter int          ADDR_W     = DEF_ADDR_W,
  parameter int          DATA_W     = DEF_DATA_W,
  parameter int          SIZE_W     = DEF_SIZE_W,
  parameter int          NCH        = DEF_NCH,
  parameter int          CNT_W      = DEF_CNT_W,
  parameter int unsigned MAX_CYCLES = DEF_MAX_CYCLES
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cfg_valid,
  input  logic [ADDR_W-1:0]     cfg_base_addr,
  input  logic [ADDR_W:0]       cfg_nbytes,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_data,
  output logic [NCH-1:0]        S_oe_ram,
  output logic [NCH-1:0]        S_we_ram,
  output logic [NCH*ADDR_W-1:0] S_addr_ram,
  output logic [NCH*DATA_W-1:0] S_Wdata_ram,
  output logic [NCH*SIZE_W-1:0] S_data_ram_size,
  input  logic [NCH-1:0]        Sout_DataRdy,
  output logic                  start_port,
  input  logic                  done_port,
  output logic                  busy,
  output logic                  run_valid,
  output logic [CNT_W-1:0]      run_cycles,
  output logic                  run_timeout
);

  localparam logic [ADDR_W:0] IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};

  seq_state_t        state;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W:0]   nbytes;
  logic [ADDR_W:0]   idx;
  logic [ADDR_W:0]   idx_inc;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_byte;
  logic              wd_finish;
  logic [CNT_W-1:0]  wd_cycles;
  logic              wd_timeout;
  logic              unused_rdy;

  assign idx_inc    = idx + IDX_ONE;
  assign unused_rdy = ^Sout_DataRdy;

  hls_cycle_watchdog #(
    .CNT_W     (CNT_W),
    .MAX_CYCLES(MAX_CYCLES)
  ) u_watchdog (
    .clock         (clock),
    .reset         (reset),
    .clear         (state == ST_START),
    .enable        (state == ST_RUN),
    .done          (done_port),
    .finish        (wd_finish),
    .result_cycles (wd_cycles),
    .result_timeout(wd_timeout)
  );

  // Only channel 0 is ever driven; write fields are zeroed whenever no write is pending.
  always_comb begin
    S_oe_ram        = '0;
    S_we_ram        = '0;
    S_addr_ram      = '0;
    S_Wdata_ram     = '0;
    S_data_ram_size = '0;
    S_we_ram[0]                 = wr_en;
    S_addr_ram[ADDR_W-1:0]      = wr_addr;
    S_Wdata_ram[7:0]            = wr_byte;
    S_data_ram_size[SIZE_W-1:0] = wr_en ? SIZE_W'(SIZE_BYTE) : '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      base        <= '0;
      nbytes      <= '0;
      idx         <= '0;
      in_ready    <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_byte     <= '0;
      start_port  <= 1'b0;
      busy        <= 1'b0;
      run_valid   <= 1'b0;
      run_cycles  <= '0;
      run_timeout <= 1'b0;
    end else begin
      start_port <= 1'b0;
      run_valid  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cfg_valid) begin
            base   <= cfg_base_addr;
            nbytes <= cfg_nbytes;
            idx    <= '0;
            busy   <= 1'b1;
            if (cfg_nbytes == '0) begin
              state      <= ST_START;
              start_port <= 1'b1;
            end else begin
              state    <= ST_LOAD;
              in_ready <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            wr_en    <= 1'b1;
            wr_addr  <= base + idx[ADDR_W-1:0];
            wr_byte  <= in_data;
            state    <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (Sout_DataRdy[0]) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_byte <= '0;
            idx     <= idx_inc;
            if (idx_inc == nbytes) begin
              state      <= ST_START;
              start_port <= 1'b1;
            end else begin
              state    <= ST_LOAD;
              in_ready <= 1'b1;
            end
          end
        end
        ST_START: begin
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (wd_finish) begin
            state       <= ST_REPORT;
            run_valid   <= 1'b1;
            run_cycles  <= wd_cycles;
            run_timeout <= wd_timeout;
          end
        end
        ST_REPORT: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hls_run_sequencer.sv
// tb/tb_hls_run_sequencer.sv - directed scoreboard bench for the run sequencer
module tb_hls_run_sequencer;

  logic         clock = 1'b0;
  logic         reset;
  logic         cfg_valid;
  logic [8:0]   cfg_base_addr;
  logic [9:0]   cfg_nbytes;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic [1:0]   S_oe_ram;
  logic [1:0]   S_we_ram;
  logic [17:0]  S_addr_ram;
  logic [127:0] S_Wdata_ram;
  logic [13:0]  S_data_ram_size;
  logic [1:0]   Sout_DataRdy = 2'b00;
  logic         start_port;
  logic         done_port = 1'b0;
  logic         busy;
  logic         run_valid;
  logic [31:0]  run_cycles;
  logic         run_timeout;

  hls_run_sequencer #(
    .ADDR_W(9), .DATA_W(64), .SIZE_W(7), .NCH(2), .CNT_W(32), .MAX_CYCLES(16)
  ) dut (
    .clock(clock), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_base_addr(cfg_base_addr), .cfg_nbytes(cfg_nbytes),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
    .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
    .Sout_DataRdy(Sout_DataRdy), .start_port(start_port), .done_port(done_port),
    .busy(busy), .run_valid(run_valid), .run_cycles(run_cycles), .run_timeout(run_timeout)
  );

  always #5 clock = ~clock;

  typedef struct { logic [8:0] addr; logic [7:0] data; } wr_t;
  typedef struct { logic [31:0] cycles; logic timeout; } run_t;

  wr_t  exp_wr[$];
  run_t exp_run[$];

  int total = 0;
  int bad = 0;
  int rdy_delay = 0;
  int done_delay = 0;
  int we_rises = 0;
  int starts = 0;
  int starts_exp = 0;
  int runs_seen = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  // Slave RAM model: completes the write rdy_delay cycles after WE rises.
  int we_cnt = 0;
  always @(negedge clock) begin
    if (S_we_ram[0]) begin
      Sout_DataRdy[0] = (we_cnt == rdy_delay);
      we_cnt++;
    end else begin
      Sout_DataRdy = 2'b00;
      we_cnt = 0;
    end
  end

  // HLS top model: raises done done_delay cycles after start (0 = never).
  bit armed = 1'b0;
  int k = 0;
  always @(negedge clock) begin
    if (reset) begin
      armed = 1'b0;
      done_port = 1'b0;
    end else begin
      done_port = 1'b0;
      if (start_port) begin
        armed = 1'b1;
        k = 0;
      end else if (armed) begin
        k++;
        if (done_delay != 0 && k == done_delay) begin
          done_port = 1'b1;
          armed = 1'b0;
        end
        if (run_valid) armed = 1'b0;
      end
    end
  end

  bit prev_we = 1'b0;
  bit prev_start = 1'b0;
  bit prev_rv = 1'b0;
  always @(negedge clock) begin
    wr_t  w;
    run_t r;
    if (!reset) begin
      check("upper_ch_zero", |{S_oe_ram, S_we_ram[1], S_addr_ram[17:9],
                               S_Wdata_ram[127:8], S_data_ram_size[13:7]}, 0);
      if (!S_we_ram[0])
        check("idle_slave_zero", |{S_addr_ram, S_Wdata_ram, S_data_ram_size}, 0);
      if (S_we_ram[0] && !prev_we) begin
        we_rises++;
        if (exp_wr.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          w = exp_wr.pop_front();
          check("wr_addr", S_addr_ram, {9'd0, w.addr});
          check("wr_data", S_Wdata_ram, {120'd0, w.data});
          check("wr_size", S_data_ram_size, 14'd8);
        end
      end
      if (start_port) begin
        starts++;
        check("start_single", prev_start, 0);
        check("start_after_writes", exp_wr.size(), 0);
      end
      if (run_valid) begin
        runs_seen++;
        check("run_valid_single", prev_rv, 0);
        check("busy_in_report", busy, 1);
        if (exp_run.size() == 0) begin
          check("unexpected_run_valid", 1, 0);
        end else begin
          r = exp_run.pop_front();
          check("run_cycles", run_cycles, r.cycles);
          check("run_timeout", run_timeout, r.timeout);
        end
      end
    end
    prev_we = S_we_ram[0];
    prev_start = start_port;
    prev_rv = run_valid;
  end

  task automatic do_cfg(input logic [8:0] base, input logic [9:0] n);
    @(negedge clock);
    cfg_valid = 1'b1;
    cfg_base_addr = base;
    cfg_nbytes = n;
    @(negedge clock);
    cfg_valid = 1'b0;
  endtask

  task automatic send_bytes(input logic [8:0] base, input int first, input int n,
                            input logic [7:0] val0, input bit toggle);
    int i = 0;
    int cyc = 0;
    wr_t w;
    while (i < n && cyc < 200) begin
      @(negedge clock);
      in_valid = toggle ? ((cyc / 2) % 2 == 0) : 1'b1;
      in_data = val0 + 8'(i);
      if (in_valid && in_ready) begin
        w.addr = base + 9'(first + i);
        w.data = in_data;
        exp_wr.push_back(w);
        i++;
      end
      cyc++;
    end
    check("bytes_accepted", i, n);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic wait_run(input int budget);
    int target = runs_seen + 1;
    int cyc = 0;
    while (runs_seen < target && cyc < budget) begin
      @(negedge clock);
      cyc++;
    end
    check("run_reported", runs_seen >= target, 1);
    check("start_count", starts, starts_exp);
  endtask

  initial begin
    int w0;
    int rs;
    reset = 1'b1;
    cfg_valid = 1'b0;
    cfg_base_addr = '0;
    cfg_nbytes = '0;
    in_valid = 1'b0;
    in_data = '0;
    repeat (3) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_start", start_port, 0);
    check("rst_run_valid", run_valid, 0);
    check("rst_run_cycles", run_cycles, 0);
    check("rst_run_timeout", run_timeout, 0);
    check("rst_we", S_we_ram, 0);
    reset = 1'b0;

    // zero-byte run
    w0 = we_rises;
    done_delay = 5;
    exp_run.push_back('{32'd5, 1'b0});
    starts_exp++;
    do_cfg(9'h000, 10'd0);
    wait_run(60);
    check("zero_byte_no_we", we_rises - w0, 0);
    repeat (2) @(negedge clock);
    check("run_cycles_held", run_cycles, 5);
    check("busy_back_idle", busy, 0);

    // four bytes across the address wrap, slow slave
    w0 = we_rises;
    rdy_delay = 2;
    done_delay = 7;
    exp_run.push_back('{32'd7, 1'b0});
    starts_exp++;
    do_cfg(9'h1FE, 10'd4);
    send_bytes(9'h1FE, 0, 4, 8'hA1, 1'b0);
    wait_run(100);
    check("wrap_we_count", we_rises - w0, 4);

    // gappy input, DataRdy in the first WE cycle, done right after start
    w0 = we_rises;
    rdy_delay = 0;
    done_delay = 1;
    exp_run.push_back('{32'd1, 1'b0});
    starts_exp++;
    do_cfg(9'h010, 10'd5);
    send_bytes(9'h010, 0, 5, 8'h30, 1'b1);
    wait_run(100);
    check("bp_we_count", we_rises - w0, 5);

    // watchdog, with a stray cfg during RUN that must be ignored
    w0 = we_rises;
    done_delay = 0;
    exp_run.push_back('{32'd16, 1'b1});
    starts_exp++;
    do_cfg(9'h000, 10'd0);
    repeat (5) @(negedge clock);
    cfg_valid = 1'b1;
    cfg_nbytes = 10'd3;
    @(negedge clock);
    cfg_valid = 1'b0;
    wait_run(100);
    check("timeout_no_we", we_rises - w0, 0);

    // done on the same cycle as the limit
    done_delay = 16;
    exp_run.push_back('{32'd16, 1'b0});
    starts_exp++;
    do_cfg(9'h000, 10'd0);
    wait_run(100);

    // reset during the second WRITE, then a clean run
    rdy_delay = 2;
    done_delay = 3;
    rs = runs_seen;
    do_cfg(9'h100, 10'd3);
    send_bytes(9'h100, 0, 1, 8'h55, 1'b0);
    send_bytes(9'h100, 1, 1, 8'h66, 1'b0);
    check("we_before_reset", S_we_ram[0], 1);
    #2 reset = 1'b1;
    #1;
    check("async_we", S_we_ram, 0);
    check("async_addr", S_addr_ram, 0);
    check("async_data", S_Wdata_ram, 0);
    check("async_busy", busy, 0);
    check("async_in_ready", in_ready, 0);
    exp_wr.delete();
    @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    check("no_run_after_reset", runs_seen, rs);
    w0 = we_rises;
    rdy_delay = 1;
    exp_run.push_back('{32'd3, 1'b0});
    starts_exp++;
    do_cfg(9'h0F0, 10'd2);
    send_bytes(9'h0F0, 0, 2, 8'h77, 1'b0);
    wait_run(100);
    check("post_reset_we_count", we_rises - w0, 2);
    check("runs_all_consumed", exp_run.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
